multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the shared multicycle RISC-V datapath (one ALU, one unified memory port).
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and muxes.
//  Waits on a variable-latency memory handshake and traps on illegal opcodes or memory timeout.
//  Sits between the IR opcode field and the datapath; the ALU decoder consumes alu_op.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles any memory state waits for mem_ready_i before trapping (>=1)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  run_i        in   1      start/continue execution; sampled only in IDLE
//  opcode_i     in   7      IR[6:0]; valid from DECODE onward
//  mem_ready_i  in   1      memory completes current access this cycle
//  pc_write     out  1      unconditional PC load
//  pc_write_cond out 1      PC load if ALU zero
//  pc_src       out  1      0=ALU result, 1=ALUOut register
//  ir_write     out  1      latch memory data into IR
//  iord         out  1      memory address: 0=PC, 1=ALUOut
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  alu_src_a    out  1      0=PC, 1=rs1
//  alu_src_b    out  2      00=rs2, 01=const 4, 10=imm
//  alu_op       out  2      00=add, 01=sub/compare, 10=funct-decoded
//  reg_write    out  1      register-file write enable
//  mem_to_reg   out  1      write-back select: 0=ALUOut, 1=MDR
//  trap         out  1      sticky; core halted
//  trap_cause   out  2      00=none, 01=illegal opcode, 10=memory timeout
//  state_o      out  4      current state encoding, debug
//  retired_cnt  out  CNT_W  instructions completed; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all outputs 0, trap_cause=00, retired_cnt=0, wait counter=0.
//  Reset is honored mid-access; any pending memory request is dropped.
//  Outputs decode from the state register only. Listed signals are 1 or set; all others are 0.
//  State encoding: IDLE=0 FETCH=1 DECODE=2 EXEC_R=3 WB_ALU=4 ADDR=5 MEM_RD=6 WB_MEM=7 MEM_WR=8 BRANCH=9 TRAP=10.
//  IDLE: run_i=1 -> FETCH, else stay.
//  FETCH: mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
//    ir_write=pc_write=mem_ready_i, combinational, same cycle; on ready -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target -> ALUOut). Next state by opcode_i:
//    0110011 or 0111011 -> EXEC_R; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH.
//    any other opcode -> TRAP, cause 01.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU.
//  WB_ALU: reg_write, mem_to_reg=0 -> FETCH; retired_cnt+1.
//  ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD if 0000011, else MEM_WR.
//  MEM_RD: mem_read, iord=1; on ready -> WB_MEM.
//  WB_MEM: reg_write, mem_to_reg=1 -> FETCH; retired_cnt+1.
//  MEM_WR: mem_write, iord=1; on ready -> FETCH; retired_cnt+1.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_src=1 -> FETCH; retired_cnt+1.
//  Memory wait counter:
//    clears on entry to FETCH/MEM_RD/MEM_WR; increments each cycle there with mem_ready_i=0.
//    reaching MEM_TIMEOUT with mem_ready_i=0 -> TRAP, cause 10.
//    ready on the same cycle the count reaches MEM_TIMEOUT wins: normal transition, no trap.
//  TRAP: trap=1, trap_cause held, no memory requests or enables; exits only via rst_n.
//  run_i is ignored outside IDLE; the FSM never returns to IDLE without reset.
//  Min CPI: R=4, lw=5, sw=4, beq=3 with zero-wait memory (ready in first cycle of each access).
// TESTING
//  1. Reset, run_i=1, ready always 1, opcode 0110011 -> states 1,2,3,4,1.
//     reg_write=1 only in WB_ALU; retired_cnt=1 after 4 cycles.
//  2. lw (0000011), memory ready after 3 wait cycles in MEM_RD.
//     mem_read and iord held 4 cycles, then WB_MEM with mem_to_reg=1.
//  3. sw (0100011) then beq (1100011), zero-wait.
//     mem_write 1 cycle; pc_write_cond=1 in BRANCH; retired_cnt=2.
//  4. opcode 1111111 at DECODE -> TRAP, trap=1, cause=01.
//     All enables 0 for 20 further cycles; run_i toggling has no effect.
//  5. MEM_TIMEOUT=4, ready held 0 in FETCH -> TRAP with cause=10 after 4 cycles.
//     Repeat with ready on the 4th cycle -> DECODE, no trap.
//  6. Assert rst_n=0 mid MEM_RD wait -> outputs 0 immediately, without a clock edge.
//     state_o=0, retired_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// Moore control FSM for the shared multicycle RISC-V datapath (FETCH/DECODE/EXEC/MEM/WB).
// Outputs decode from state (FETCH ir/pc write also follow mem_ready_i); memory waits bounded by MEM_TIMEOUT.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_ALU = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_R32  = 7'b0111011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause_q;
    logic [1:0]        cause_nx;
    logic              retire;
    logic              mem_state;
    logic              timed_out;

    assign mem_state  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Ready arriving on the final allowed cycle wins over the timeout.
    assign timed_out  = !mem_ready_i && (wait_cnt == WAIT_LAST);
    assign trap_cause = cause_q;
    assign state_o    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cause_q     <= 2'b00;
            retired_cnt <= '0;
        end else begin
            state   <= state_nx;
            cause_q <= cause_nx;
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (mem_state && !mem_ready_i) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx      = state;
        cause_nx      = cause_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        trap          = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_i) state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready_i;
                pc_write  = mem_ready_i;
                if (mem_ready_i) begin
                    state_nx = S_DECODE;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b10;
                case (opcode_i)
                    OP_R, OP_R32:     state_nx = S_EXEC_R;
                    OP_LOAD, OP_STOR: state_nx = S_ADDR;
                    OP_BR:            state_nx = S_BRANCH;
                    default: begin
                        state_nx = S_TRAP;
                        cause_nx = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_nx  = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready_i) begin
                    state_nx = S_WB_MEM;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready_i) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                retire        = 1'b1;
                state_nx      = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for multicycle_ctrl: per-instruction expectations from CPI/wait rules.
module tb_multicycle_ctrl;

    localparam int T  = 4;
    localparam int CW = 32;

    localparam int K_R   = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_BEQ = 3;
    localparam int K_ILL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_i = 1'b0;
    logic [6:0]    opcode_i = 7'd0;
    logic          mem_ready_i = 1'b0;
    logic          pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write;
    logic          alu_src_a, reg_write, mem_to_reg, trap;
    logic [1:0]    alu_src_b, alu_op, trap_cause;
    logic [3:0]    state_o;
    logic [CW-1:0] retired_cnt;
    logic [16:0]   ctl;

    multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap, trap_cause};

    typedef struct {
        bit     is_trap;
        int     cause;
        int     cyc, rd, wr, iord, irw, pcw, rw, m2r, pcwc, pcsrc, aluf;
        longint cnt;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;
    longint model_cnt = 0;

    int          a_cyc, a_rd, a_wr, a_iord, a_irw, a_pcw, a_rw, a_m2r, a_pcwc, a_pcsrc, a_aluf;
    logic [CW-1:0] last_cnt;
    bit          in_trap;
    int          trap_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_acc();
        a_cyc = 0; a_rd = 0; a_wr = 0; a_iord = 0; a_irw = 0; a_pcw = 0;
        a_rw = 0; a_m2r = 0; a_pcwc = 0; a_pcsrc = 0; a_aluf = 0;
    endtask

    task automatic compare(input bit is_trap);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got %s with empty scoreboard (t=%0t)",
                     is_trap ? "trap" : "retire", $time);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(is_trap), 64'(e.is_trap));
        chk("cycles", 64'(a_cyc), 64'(e.cyc));
        chk("mem_read_cycles", 64'(a_rd), 64'(e.rd));
        chk("mem_write_cycles", 64'(a_wr), 64'(e.wr));
        chk("iord_cycles", 64'(a_iord), 64'(e.iord));
        chk("ir_write_cycles", 64'(a_irw), 64'(e.irw));
        chk("pc_write_cycles", 64'(a_pcw), 64'(e.pcw));
        chk("reg_write_cycles", 64'(a_rw), 64'(e.rw));
        chk("mem_to_reg_cycles", 64'(a_m2r), 64'(e.m2r));
        chk("pc_write_cond_cycles", 64'(a_pcwc), 64'(e.pcwc));
        chk("pc_src_cycles", 64'(a_pcsrc), 64'(e.pcsrc));
        chk("alu_funct_cycles", 64'(a_aluf), 64'(e.aluf));
        chk("retired_cnt", 64'(retired_cnt), 64'(e.cnt));
        chk("trap_cause", 64'(trap_cause), 64'(e.cause));
    endtask

    // Monitor: accumulates per-instruction activity and pops on each retirement or trap.
    always @(negedge clk) begin
        if (!rst_n) begin
            clear_acc();
            last_cnt = '0;
            in_trap  = 1'b0;
        end else begin
            if (retired_cnt != last_cnt) begin
                compare(1'b0);
                last_cnt = retired_cnt;
                clear_acc();
            end
            if (trap && !in_trap) begin
                compare(1'b1);
                in_trap = 1'b1;
                trap_c  = int'(trap_cause);
                clear_acc();
            end else if (in_trap) begin
                chk("trap_quiet", 64'(ctl[16:3]), 64'd0);
                chk("trap_state", 64'(state_o), 64'd10);
                chk("trap_cause_hold", 64'(trap_cause), 64'(trap_c));
                chk("trap_sticky", 64'(trap), 64'd1);
            end
            if (!trap && state_o != 4'd0) begin
                a_cyc++;
                a_rd    += int'(mem_read);
                a_wr    += int'(mem_write);
                a_iord  += int'(iord);
                a_irw   += int'(ir_write);
                a_pcw   += int'(pc_write);
                a_rw    += int'(reg_write);
                a_m2r   += int'(mem_to_reg);
                a_pcwc  += int'(pc_write_cond);
                a_pcsrc += int'(pc_src);
                a_aluf  += int'(alu_op == 2'b10);
            end
        end
    end

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0111011: return K_R;
            7'b0000011:             return K_LW;
            7'b0100011:             return K_SW;
            7'b1100011:             return K_BEQ;
            default:                return K_ILL;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] legal_op();
        logic [6:0] ops [5];
        ops = '{7'b0110011, 7'b0111011, 7'b0000011, 7'b0100011, 7'b1100011};
        return ops[$urandom_range(0, 4)];
    endfunction

    // Inputs for the cycle that starts at the next rising edge.
    task automatic drive(input logic r, input logic [6:0] op);
        @(posedge clk);
        #1;
        mem_ready_i = r;
        opcode_i    = op;
        run_i       = rnd_bit();
    endtask

    // wf/wm: not-ready cycles before ready in FETCH / data access; >= T means the access times out.
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
        exp_t e;
        int   k;
        int   mem;
        k = kind_of(op);
        e = '{default: 0};
        e.cnt = model_cnt;
        if (wf >= T) begin
            e.is_trap = 1'b1; e.cause = 2; e.cyc = T; e.rd = T;
        end else begin
            e.cyc = wf + 2; e.rd = wf + 1; e.irw = 1; e.pcw = 1;
            mem = (wm >= T) ? T : wm + 1;
            case (k)
                K_R:   begin e.cyc += 2; e.aluf = 1; e.rw = 1; end
                K_BEQ: begin e.cyc += 1; e.pcwc = 1; e.pcsrc = 1; end
                K_LW, K_SW: begin
                    e.cyc += 1 + mem;
                    e.iord = mem;
                    if (k == K_LW) e.rd += mem; else e.wr += mem;
                    if (wm >= T) begin
                        e.is_trap = 1'b1; e.cause = 2;
                    end else if (k == K_LW) begin
                        e.cyc += 1; e.rw = 1; e.m2r = 1;
                    end
                end
                default: begin e.is_trap = 1'b1; e.cause = 1; end
            endcase
            if (!e.is_trap) begin
                model_cnt++;
                e.cnt = model_cnt;
            end
        end
        exp_q.push_back(e);

        for (int i = 0; i < wf && i < T; i++) drive(1'b0, rnd_op());
        if (wf >= T) return;
        drive(1'b1, rnd_op());
        drive(rnd_bit(), op);
        case (k)
            K_R:   repeat (2) drive(rnd_bit(), op);
            K_BEQ: drive(rnd_bit(), op);
            K_LW, K_SW: begin
                drive(rnd_bit(), op);
                for (int i = 0; i < wm && i < T; i++) drive(1'b0, op);
                if (wm < T) begin
                    drive(1'b1, op);
                    if (k == K_LW) drive(rnd_bit(), op);
                end
            end
            default: ;
        endcase
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        run_i = 1'b0;
        mem_ready_i = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic end_run(input string name);
        repeat (2) drive(1'b0, rnd_op());
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic trap_phase(input string name);
        repeat (22) drive(rnd_bit(), rnd_op());
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic random_instrs(input int n);
        for (int i = 0; i < n; i++) run_instr(legal_op(), $urandom_range(0, T - 1), $urandom_range(0, T - 1));
    endtask

    initial begin
        logic [6:0] ill;
        #3;
        chk("reset_ctl", 64'(ctl), 64'd0);
        chk("reset_state", 64'(state_o), 64'd0);
        chk("reset_retired", 64'(retired_cnt), 64'd0);
        apply_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("idle_hold", 64'(state_o), 64'd0);

        // Directed R, lw with 3 waits, sw, beq, fetch ready on the last allowed cycle, then random mix.
        run_i = 1'b1;
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 3);
        run_instr(7'b0100011, 0, 0);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b0111011, T - 1, 0);
        run_instr(7'b0100011, 1, T - 1);
        random_instrs(40);
        end_run("drain_random");

        // Illegal opcode.
        apply_reset();
        run_i = 1'b1;
        random_instrs(3);
        run_instr(7'b1111111, 0, 0);
        trap_phase("drain_illegal_fixed");

        apply_reset();
        run_i = 1'b1;
        random_instrs(2);
        do ill = rnd_op(); while (kind_of(ill) != K_ILL);
        run_instr(ill, $urandom_range(0, T - 1), 0);
        trap_phase("drain_illegal_rand");

        // Memory timeouts in FETCH, MEM_RD and MEM_WR.
        apply_reset();
        run_i = 1'b1;
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0110011, T, 0);
        trap_phase("drain_fetch_timeout");

        apply_reset();
        run_i = 1'b1;
        random_instrs(2);
        run_instr(7'b0000011, 1, T);
        trap_phase("drain_load_timeout");

        apply_reset();
        run_i = 1'b1;
        random_instrs(2);
        run_instr(7'b0100011, 0, T);
        trap_phase("drain_store_timeout");

        // Asynchronous reset in the middle of a load wait.
        apply_reset();
        run_i = 1'b1;
        random_instrs(3);
        drive(1'b1, rnd_op());
        drive(rnd_bit(), 7'b0000011);
        drive(rnd_bit(), 7'b0000011);
        drive(1'b0, 7'b0000011);
        drive(1'b0, 7'b0000011);
        @(negedge clk);
        #2;
        chk("pre_reset_drained", 64'(exp_q.size()), 64'd0);
        chk("mid_load_rd_iord", 64'({mem_read, iord}), 64'd3);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 64'(ctl), 64'd0);
        chk("async_reset_state", 64'(state_o), 64'd0);
        chk("async_reset_retired", 64'(retired_cnt), 64'd0);
        apply_reset();
        run_i = 1'b1;
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 0);
        end_run("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
